// File: rtl/stg_fetchq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stg_fetchq_pkg
//  Purpose  : Shared sizing constants for the fetch front-end and its queue.
//             SIZE_ADDR  - PC / imem address width
//             SIZE_DATA  - instruction word width
//             SIZE_FETCHQ - default fetch queue depth
//  Revision : 1.0 - initial release
// ============================================================================
package stg_fetchq_pkg;

  localparam int SIZE_ADDR   = 16;
  localparam int SIZE_DATA   = 32;
  localparam int SIZE_FETCHQ = 4;

  // Width needed to hold an occupancy value in the range 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : stg_fetchq_pkg
`default_nettype wire

// File: rtl/stg_fetchq_fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync
//  Purpose  : Single-clock FIFO with synchronous clear. The head word is a
//             direct read of the storage registers (no write-to-read bypass).
//  Ports    : clk, rst_n       - clock, asynchronous active-low reset
//             push / wdata     - write wdata at the tail
//             pop              - drop the head entry
//             clear            - empty the FIFO (wins over push and pop)
//             rdata            - head entry
//             count            - occupancy, 0..DEPTH
//  Notes    : DEPTH must be a power of two (pointers wrap naturally).
//             The caller never pushes when full nor pops when empty.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_sync
  import stg_fetchq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule : fifo_sync
`default_nettype wire

// File: rtl/stg_fetchq.sv
`default_nettype none
// ============================================================================
//  Module   : stg_fetchq
//  Purpose  : Fetch front-end. Owns the fetch PC, issues one imem read per
//             cycle (fixed 1-cycle read latency), buffers returned words with
//             their PCs in a DEPTH-entry queue and hands them to decode via a
//             valid/ready handshake. A flush redirects fetch, empties the
//             queue and drops the response that is in flight.
//  Ports    : iw_clk, iw_rst_n         - clock, asynchronous active-low reset
//             ow_mem_req, ow_mem_addr  - imem read request / address
//             iw_mem_rdata             - imem data, one cycle after request
//             iw_flush, iw_flush_pc    - redirect and its target
//             ow_valid, iw_ready       - decode handshake
//             ow_pc, ow_instr          - head entry
//             ow_count                 - queue occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module stg_fetchq
  import stg_fetchq_pkg::*;
#(
  parameter int                ADDR_W   = SIZE_ADDR,
  parameter int                DATA_W   = SIZE_DATA,
  parameter int                DEPTH    = SIZE_FETCHQ,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       iw_clk,
  input  logic                       iw_rst_n,
  output logic                       ow_mem_req,
  output logic [ADDR_W-1:0]          ow_mem_addr,
  input  logic [DATA_W-1:0]          iw_mem_rdata,
  input  logic                       iw_flush,
  input  logic [ADDR_W-1:0]          iw_flush_pc,
  output logic                       ow_valid,
  input  logic                       iw_ready,
  output logic [ADDR_W-1:0]          ow_pc,
  output logic [DATA_W-1:0]          ow_instr,
  output logic [$clog2(DEPTH+1)-1:0] ow_count
);

  localparam int              CNT_W   = cnt_width(DEPTH);
  localparam logic [CNT_W:0]  C_DEPTH = (CNT_W+1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q,       pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;   // address of the read now returning
  logic              inflight_q, inflight_d;

  logic [CNT_W-1:0]         count;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [CNT_W:0]           occ;
  logic                     valid, deq, enq, issue;
  logic [ADDR_W-1:0]        addr;

  always_comb begin
    valid = (count != '0) & ~iw_flush;
    deq   = valid & iw_ready;
    enq   = inflight_q & ~iw_flush;
    // Slots committed after this cycle if nothing new is issued: the queue
    // plus the response arriving now, minus what decode takes. Issuing only
    // while this is below DEPTH means the next response always has room.
    occ   = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, deq};
    issue = iw_flush | (occ < C_DEPTH);
    addr  = iw_flush ? iw_flush_pc : pc_q;

    pc_d       = issue ? addr + 1'b1 : pc_q;
    req_addr_d = issue ? addr : req_addr_q;
    inflight_d = issue;
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
    end
  end

  fifo_sync #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (iw_clk),
    .rst_n (iw_rst_n),
    .push  (enq),
    .pop   (deq),
    .clear (iw_flush),
    .wdata ({req_addr_q, iw_mem_rdata}),
    .rdata (head),
    .count (count)
  );

  // The request is gated by reset so no read is advertised while held in reset.
  assign ow_mem_req  = issue & iw_rst_n;
  assign ow_mem_addr = addr;
  assign ow_valid    = valid;
  assign ow_pc       = head[ADDR_W+DATA_W-1:DATA_W];
  assign ow_instr    = head[DATA_W-1:0];
  assign ow_count    = count;

endmodule : stg_fetchq
`default_nettype wire
